match_controller: RTL

Game-flow sequencer for the Pong engine. It owns the match state machine (startup menu, serve delay, rally, point scoring, game over), debounces the four player buttons, and keeps the scores. It drives the ball datapath through run/show/recentre controls and a serve direction. It sits between the board buttons, the ball/paddle datapath (which reports wall misses) and the renderer (which shows scores and menus).

---
 rtl/match_controller_if.sv | 36 +++
 rtl/match_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/match_controller_if.sv
//------------------------------------------------------------------------------
// match_controller_if : button, miss and game-flow signals of the match sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface match_controller_if;
  logic [3:0] btn_n;
  logic       miss_left;
  logic       miss_right;
  logic [3:0] btn_db;
  logic [2:0] state;
  logic       run_en;
  logic       sq_shown;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_startup;
  logic       game_over;
  logic       winner;

  modport master (
    input  btn_n, miss_left, miss_right,
    output btn_db, state, run_en, sq_shown, ball_reset, serve_dir,
           score_p1, score_p2, game_startup, game_over, winner
  );

  modport slave (
    output btn_n, miss_left, miss_right,
    input  btn_db, state, run_en, sq_shown, ball_reset, serve_dir,
           score_p1, score_p2, game_startup, game_over, winner
  );
endinterface

`default_nettype wire

// File: rtl/match_controller.sv
//------------------------------------------------------------------------------
// match_controller : Pong match sequencer - button debounce, scoring, game FSM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module match_controller #(
  parameter int CLK_HZ      = 25_175_000,
  parameter int LOCKOUT     = 2_500_000,
  parameter int SERVE_DELAY = 50_350_000,
  parameter int DEBOUNCE    = 250_000,
  parameter int MAX_SCORE   = 11
) (
  input  wire logic          clk_0,
  input  wire logic          rst,
  match_controller_if.master bus
);

  localparam int c_db_w   = $clog2(DEBOUNCE + 1);
  localparam int c_lock_w = $clog2(LOCKOUT + 1);
  localparam int c_dly_w  = $clog2(SERVE_DELAY + 1);

  localparam logic [c_db_w-1:0]   c_db_max    = c_db_w'(DEBOUNCE);
  localparam logic [c_lock_w-1:0] c_lock_max  = c_lock_w'(LOCKOUT - 1);
  localparam logic [c_dly_w-1:0]  c_dly_last  = c_dly_w'(SERVE_DELAY - 1);
  localparam logic [3:0]          c_max_score = 4'(MAX_SCORE);

  if (CLK_HZ <= 0 || LOCKOUT < 1 || SERVE_DELAY < 1 || DEBOUNCE < 1 ||
      MAX_SCORE < 1 || MAX_SCORE > 15) begin : g_param_check
    $error("match_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_SERVE   = 3'd1,
    S_RALLY   = 3'd2,
    S_POINT   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_btn_db;
  logic [3:0]        r_db_prev;
  logic [c_db_w-1:0] r_db_cnt [4];
  logic              r_press;

  // Synchronizer idles high (released) so reset never looks like a press.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_btn_db  <= '0;
      r_db_prev <= '0;
      r_press   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= bus.btn_n;
      r_sync2   <= r_sync1;
      r_db_prev <= r_btn_db;
      r_press   <= |(r_btn_db & ~r_db_prev);
      for (int i = 0; i < 4; i++) begin
        if (~r_sync2[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == c_db_max) begin
          r_btn_db[i] <= ~r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + c_db_w'(1);
        end
      end
    end
  end

  state_t              r_state;
  logic [c_lock_w-1:0] r_lock_cnt;
  logic [c_dly_w-1:0]  r_dly_cnt;
  logic [3:0]          r_score_p1;
  logic [3:0]          r_score_p2;
  logic                r_serve_dir;
  logic                r_winner;
  logic                r_run_en;
  logic                r_sq_shown;
  logic                r_ball_reset;
  logic                r_game_startup;
  logic                r_game_over;

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      r_state        <= S_STARTUP;
      r_lock_cnt     <= '0;
      r_dly_cnt      <= '0;
      r_score_p1     <= '0;
      r_score_p2     <= '0;
      r_serve_dir    <= 1'b0;
      r_winner       <= 1'b0;
      r_run_en       <= 1'b0;
      r_sq_shown     <= 1'b0;
      r_ball_reset   <= 1'b0;
      r_game_startup <= 1'b1;
      r_game_over    <= 1'b0;
    end else begin
      r_ball_reset <= 1'b0;
      case (r_state)
        S_STARTUP, S_OVER: begin
          // Presses only count once the lockout counter has saturated.
          if (r_lock_cnt != c_lock_max) begin
            r_lock_cnt <= r_lock_cnt + c_lock_w'(1);
          end else if (r_press) begin
            r_score_p1     <= '0;
            r_score_p2     <= '0;
            r_serve_dir    <= 1'b0;
            r_dly_cnt      <= '0;
            r_ball_reset   <= 1'b1;
            r_game_startup <= 1'b0;
            r_game_over    <= 1'b0;
            r_state        <= S_SERVE;
          end
        end

        S_SERVE: begin
          if (r_dly_cnt == c_dly_last) begin
            r_run_en   <= 1'b1;
            r_sq_shown <= 1'b1;
            r_state    <= S_RALLY;
          end else begin
            r_dly_cnt <= r_dly_cnt + c_dly_w'(1);
          end
        end

        S_RALLY: begin
          if (bus.miss_left || bus.miss_right) begin
            r_run_en   <= 1'b0;
            r_sq_shown <= 1'b0;
            r_state    <= S_POINT;
            // A simultaneous double miss is a dead ball: no score, same server.
            if (bus.miss_right && !bus.miss_left) begin
              if (r_score_p1 != c_max_score) begin
                r_score_p1 <= r_score_p1 + 4'd1;
              end
              r_serve_dir <= 1'b1;
            end else if (bus.miss_left && !bus.miss_right) begin
              if (r_score_p2 != c_max_score) begin
                r_score_p2 <= r_score_p2 + 4'd1;
              end
              r_serve_dir <= 1'b0;
            end
          end
        end

        S_POINT: begin
          if (r_score_p1 == c_max_score || r_score_p2 == c_max_score) begin
            r_winner    <= (r_score_p2 == c_max_score);
            r_lock_cnt  <= '0;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_dly_cnt    <= '0;
            r_ball_reset <= 1'b1;
            r_state      <= S_SERVE;
          end
        end

        default: begin
          r_run_en       <= 1'b0;
          r_sq_shown     <= 1'b0;
          r_game_startup <= 1'b1;
          r_game_over    <= 1'b0;
          r_lock_cnt     <= '0;
          r_state        <= S_STARTUP;
        end
      endcase
    end
  end

  assign bus.btn_db       = r_btn_db;
  assign bus.state        = r_state;
  assign bus.run_en       = r_run_en;
  assign bus.sq_shown     = r_sq_shown;
  assign bus.ball_reset   = r_ball_reset;
  assign bus.serve_dir    = r_serve_dir;
  assign bus.score_p1     = r_score_p1;
  assign bus.score_p2     = r_score_p2;
  assign bus.game_startup = r_game_startup;
  assign bus.game_over    = r_game_over;
  assign bus.winner       = r_winner;

endmodule

`default_nettype wire
